// File: rtl/alu_flags_seq_if.sv
// Handshake and data bundle for alu_flags_seq: the request side (operands and opcode)
// and the response side (result, flags, busy).
interface alu_flags_seq_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   ALUControl;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  modport master (
    output in_valid, A, B, ALUControl, set_flags, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, A, B, ALUControl, set_flags, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_flags_seq.sv
// Registered ALU with persistent NZCV flags: single-cycle add/sub/logic ops,
// carry-chained ADC/SBC, and one-bit-per-cycle logical shifts.
module alu_flags_seq #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  alu_flags_seq_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  work_q, work_d;
  logic          left_q, left_d;
  logic          sf_q, sf_d;
  logic [N-1:0]  result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic [N-1:0]  bop;
  logic          cin;
  logic [N:0]    sum;
  logic          sum_v;
  logic [N-1:0]  lres;
  logic [SW-1:0] shamt;
  logic [N-1:0]  shifted;
  logic          shout;

  assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = (state_q == SHIFT);
  assign accept        = bus.in_valid && bus.in_ready;

  // Shared adder: op[0] selects subtract, op[2] selects the stored carry as carry-in.
  always_comb begin
    bop     = bus.ALUControl[0] ? ~bus.B : bus.B;
    cin     = bus.ALUControl[2] ? flags_q[1] : bus.ALUControl[0];
    sum     = {1'b0, bus.A} + {1'b0, bop} + {{N{1'b0}}, cin};
    sum_v   = (bus.A[N-1] == bop[N-1]) && (sum[N-1] != bus.A[N-1]);
    lres    = bus.ALUControl[0] ? (bus.A | bus.B) : (bus.A & bus.B);
    shamt   = bus.B[SW-1:0];
    shifted = left_q ? {work_q[N-2:0], 1'b0} : {1'b0, work_q[N-1:1]};
    shout   = left_q ? work_q[N-1] : work_q[0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    left_d      = left_q;
    sf_d        = sf_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.ALUControl)
            3'b010, 3'b011: begin
              result_d    = lres;
              out_valid_d = 1'b1;
              if (bus.set_flags) flags_d = {lres[N-1], lres == '0, flags_q[1:0]};
            end
            3'b110, 3'b111: begin
              if (shamt == '0) begin
                result_d    = bus.A;
                out_valid_d = 1'b1;
                if (bus.set_flags) flags_d = {bus.A[N-1], bus.A == '0, flags_q[1:0]};
              end else begin
                state_d = SHIFT;
                cnt_d   = shamt;
                work_d  = bus.A;
                left_d  = !bus.ALUControl[0];
                sf_d    = bus.set_flags;
              end
            end
            default: begin
              result_d    = sum[N-1:0];
              out_valid_d = 1'b1;
              if (bus.set_flags) flags_d = {sum[N-1], sum[N-1:0] == '0, sum[N], sum_v};
            end
          endcase
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SW'(1);
        // Final step: the bit leaving now becomes C.
        if (cnt_q == SW'(1)) begin
          state_d     = IDLE;
          result_d    = shifted;
          out_valid_d = 1'b1;
          if (sf_q) flags_d = {shifted[N-1], shifted == '0, shout, flags_q[0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      left_q      <= 1'b0;
      sf_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      left_q      <= left_d;
      sf_q        <= sf_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_flags_seq.sv
// Bench for alu_flags_seq at N=4: directed vectors with literal expectations plus
// a per-cycle comparison against an arithmetic reference model.
module tb_alu_flags_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_flags_seq_if #(.N(W)) bus ();
  alu_flags_seq #(.N(W)) dut (.clk(clk), .reset(rst), .bus(bus.slave));

  typedef struct {
    logic [3:0] res;
    logic [3:0] fl;
    int         lat;
  } pred_t;

  function automatic int sx(int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  // Reference: plain integer arithmetic on the opcode's meaning.
  function automatic pred_t predict(int a, int b, int op, bit sf, logic [3:0] f);
    pred_t p;
    int r, sv, s, cc, vv, cin;
    cc = int'(f[1]); vv = int'(f[0]); cin = int'(f[1]);
    p.lat = 0; r = 0; sv = 0;
    case (op)
      0: begin r = a + b;           sv = sx(a) + sx(b);           cc = int'(r > 15);  vv = int'(sv > 7 || sv < -8); end
      1: begin r = a - b;           sv = sx(a) - sx(b);           cc = int'(r >= 0);  vv = int'(sv > 7 || sv < -8); end
      4: begin r = a + b + cin;     sv = sx(a) + sx(b) + cin;     cc = int'(r > 15);  vv = int'(sv > 7 || sv < -8); end
      5: begin r = a - b - 1 + cin; sv = sx(a) - sx(b) - 1 + cin; cc = int'(r >= 0);  vv = int'(sv > 7 || sv < -8); end
      2: r = a & b;
      3: r = a | b;
      6: begin s = b % 4; r = (a << s) % 16; if (s > 0) cc = (a >> (4 - s)) % 2; p.lat = s; end
      default: begin s = b % 4; r = a >> s; if (s > 0) cc = (a >> (s - 1)) % 2; p.lat = s; end
    endcase
    p.res = 4'(r & 15);
    p.fl  = sf ? {p.res[3], p.res == 4'd0, cc[0], vv[0]} : f;
    return p;
  endfunction

  logic       m_ov;
  logic [3:0] m_res, m_fl;
  int         m_cnt;
  pred_t      pend, p_now;
  logic       m_ready;

  assign m_ready = (m_cnt == 0) && (!m_ov || bus.out_ready);
  always_comb p_now = predict(int'(bus.A), int'(bus.B), int'(bus.ALUControl), bus.set_flags, m_fl);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov <= 1'b0; m_res <= '0; m_fl <= '0; m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_ov <= 1'b1; m_res <= pend.res; m_fl <= pend.fl; end
    end else begin
      if (m_ov && bus.out_ready) m_ov <= 1'b0;
      if (bus.in_valid && m_ready) begin
        if (p_now.lat == 0) begin
          m_ov <= 1'b1; m_res <= p_now.res; m_fl <= p_now.fl;
        end else begin
          m_cnt <= p_now.lat; pend <= p_now;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && chk_en) begin
      chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("cyc_busy", 32'(bus.busy), 32'(m_cnt > 0));
      chk("cyc_in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("cyc_flags", 32'(bus.flags), 32'(m_fl));
      if (m_ov) chk("cyc_result", 32'(bus.result), 32'(m_res));
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic sf);
    int n = 0;
    bus.A = a; bus.B = b; bus.ALUControl = op; bus.set_flags = sf; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'(0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [3:0] er, input logic [3:0] ef, input int elat);
    int n = 0;
    #1;
    while (!bus.out_valid && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk({name, "_timeout"}, 32'(n), 32'(elat));
    else begin
      chk({name, "_result"}, 32'(bus.result), 32'(er));
      chk({name, "_flags"}, 32'(bus.flags), 32'(ef));
      chk({name, "_latency"}, 32'(n), 32'(elat));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ALUControl = '0;
    bus.set_flags = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_result", 32'(bus.result), 32'(4'b0000));
    chk("rst_flags", 32'(bus.flags), 32'(4'b0000));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);

    issue(4'b0110, 4'b0111, 3'b000, 1'b1); wait_out("add", 4'b1101, 4'b1001, 0);
    issue(4'b0110, 4'b0110, 3'b001, 1'b1); wait_out("sub_eq", 4'b0000, 4'b0110, 0);
    issue(4'b0110, 4'b0111, 3'b001, 1'b1); wait_out("sub_neg", 4'b1111, 4'b1000, 0);
    issue(4'b1111, 4'b0001, 3'b000, 1'b1); wait_out("add_wrap", 4'b0000, 4'b0110, 0);
    issue(4'b0010, 4'b0011, 3'b100, 1'b1); wait_out("adc_c1", 4'b0110, 4'b0000, 0);
    issue(4'b0010, 4'b0011, 3'b100, 1'b0); wait_out("adc_nosf", 4'b0101, 4'b0000, 0);

    issue(4'b0110, 4'b0011, 3'b110, 1'b1);
    bus.out_ready = 1'b0;
    wait_out("lsl3", 4'b0000, 4'b0110, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("hold_result", 32'(bus.result), 32'(4'b0000));
      chk("hold_in_ready", 32'(bus.in_ready), 32'(0));
      chk("hold_out_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    issue(4'b1001, 4'b0001, 3'b111, 1'b1); wait_out("lsr1", 4'b0100, 4'b0010, 1);
    issue(4'b0101, 4'b0011, 3'b101, 1'b1); wait_out("sbc", 4'b0010, 4'b0010, 0);
    issue(4'b1100, 4'b1010, 3'b010, 1'b1); wait_out("and", 4'b1000, 4'b1010, 0);
    issue(4'b0000, 4'b0000, 3'b011, 1'b1); wait_out("or_zero", 4'b0000, 4'b0110, 0);
    issue(4'b0111, 4'b0001, 3'b000, 1'b1); wait_out("add_ovf", 4'b1000, 4'b1001, 0);
    issue(4'b0101, 4'b0000, 3'b110, 1'b1); wait_out("lsl0", 4'b0101, 4'b0001, 0);

    // Back-to-back single-cycle adds with the consumer always ready.
    bus.ALUControl = 3'b000; bus.set_flags = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.A = 4'(i); bus.B = 4'(i + 5);
      chk("b2b_in_ready", 32'(bus.in_ready), 32'(1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_last_result", 32'(bus.result), 32'(4'b1011));
    chk("b2b_last_flags", 32'(bus.flags), 32'(4'b1000));
    chk("b2b_last_valid", 32'(bus.out_valid), 32'(1));
    @(negedge clk);

    issue(4'b0110, 4'b0011, 3'b110, 1'b1);
    chk("pre_rst_busy", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_flags", 32'(bus.flags), 32'(4'b0000));
    chk("mid_rst_result", 32'(bus.result), 32'(4'b0000));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue(4'b0011, 4'b0100, 3'b000, 1'b1); wait_out("add_after_rst", 4'b0111, 4'b0000, 0);
    @(negedge clk); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
